mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port valid/ready memory (WIDTH x DEPTH, 1-cycle registered response).
- Accepts one read or write command at a time, drives the memory port for exactly one cycle, waits for the response and returns read data plus a completion pulse to the winning requester.
- A watchdog aborts a transaction whose response never arrives.

Parameters:
- WIDTH, 8, data width; must match memory WIDTH.
- DEPTH, 32, memory depth; must match memory DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 4, maximum WAIT cycles without m_ready before abort; must be >= 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 command pending; held with fields stable until req0_gnt.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  command address.
- req0_wdata  in  WIDTH  write data.
- req0_gnt  out  1  one-cycle pulse: command accepted.
- req0_done  out  1  one-cycle pulse: command completed.
- req0_err  out  1  one-cycle pulse, coincident with req0_done, on timeout.
- req0_rdata  out  WIDTH  last successful read data; held otherwise.
- req1_*  same set and widths as req0_*, for requester 1.
- m_valid  out  1  memory valid.
- m_wr_rd  out  1  memory write(1)/read(0).
- m_addr  out  ADDR_WIDTH  memory address.
- m_wdata  out  WIDTH  memory write data.
- m_rdata  in  WIDTH  memory read data.
- m_ready  in  1  memory ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset state: IDLE. All outputs 0, including the req*_rdata registers. Watchdog counter 0. Priority pointer favours requester 0.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If any reqN_valid is high at an edge, select a winner and latch its wr/addr/wdata into m_wr_rd/m_addr/m_wdata.
  - Set m_valid=1 and reqN_gnt=1 for the winner, then go to ISSUE.
  - If no reqN_valid is high, outputs hold and m_valid=0.
- ISSUE (exactly 1 cycle): at the next edge m_valid->0, gnt->0, watchdog counter cleared, go to WAIT.
- WAIT:
  - At each edge: if m_ready=1, then reqN_done=1; on a read, reqN_rdata<=m_rdata; on a write, rdata is unchanged. Go to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, pulse reqN_done=1 and reqN_err=1, leave rdata unchanged, go to IDLE.
- Arbitration:
  - When only one request is pending, it wins.
  - When both are pending, the requester not served last wins.
  - The pointer updates on completion, including timeout completion.
- Latency with the standard memory:
  - IDLE accept edge E0: gnt high in cycle E0..E1.
  - Memory samples valid at E1 and raises ready.
  - Arbiter samples ready at E2: done high in cycle E2..E3.
  - Next accept is possible at edge E3 at the earliest, giving 1 transaction per 3 cycles.
- Requests arriving during ISSUE/WAIT are ignored until IDLE.
- A requester that deasserts valid before gnt is treated as never having requested; no error is flagged.
- Addresses pass through unmodified. No range check is needed, since ADDR_WIDTH covers DEPTH, e.g. addr DEPTH-1 = 31 is valid.
- m_ready while in IDLE or ISSUE is ignored.
- Reset mid-transaction: return to IDLE immediately. No done/err pulse for the aborted command, all outputs 0, pointer favours requester 0. The requester must re-issue.

Test Plan:
- Reset, then req0 write addr 5 data 0xA5: req0_gnt one cycle after accept, req0_done two cycles later, req0_err=0. Then req0 read addr 5 -> req0_rdata=0xA5 together with req0_done.
- req0 and req1 both assert in the same cycle after reset (writes to addr 1 = 0x11 and addr 2 = 0x22): req0 granted first, req1 granted at the next IDLE. With both held continuously, grants alternate 0,1,0,1 and each done is 3 cycles apart.
- req1 alone, four back-to-back reads of addr 31 (preloaded 0x3C): every one is granted to req1, req1_rdata=0x3C, req0 outputs stay 0.
- Memory model forces m_ready=0, req1 read addr 7: after TIMEOUT=4 WAIT cycles, req1_done=1 and req1_err=1 in the same cycle, req1_rdata keeps its prior value, busy drops the next cycle.
- Assert rst for 1 cycle during WAIT of a req1 write: no req1_done, busy=0, all outputs 0. With both requesting after reset, req0 wins.
- Read/write mix on one requester: write 0xFF to addr 0, read addr 0 -> 0xFF. A subsequent write does not change req0_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Round-robin arbiter and sequencer placing two requesters in front of one
// single-port valid/ready memory that answers one cycle after it samples
// m_valid. Only one command is in flight at a time. A watchdog ends a
// command whose response never comes and flags it with an error pulse.
//
// Handshake: a requester holds reqN_valid high, with its command fields
// stable, until it sees a one-cycle reqN_gnt. A one-cycle reqN_done follows
// when the command ends. reqN_err is high in that same cycle only on a
// timeout. Toward the memory, m_valid is high for exactly one cycle per
// command. m_ready is only looked at while a response is awaited.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   reqN_valid/wr/addr/wdata      command from requester N (N = 0, 1)
//   reqN_gnt, reqN_done, reqN_err one-cycle pulses to requester N
//   reqN_rdata                    last successful read data for requester N
//   m_valid/wr_rd/addr/wdata      memory command
//   m_rdata, m_ready              memory response
//   busy                          a command is in progress (state != IDLE)
module mem_port_arbiter #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_wdata,
    output logic                  req0_gnt,
    output logic                  req0_done,
    output logic                  req0_err,
    output logic [WIDTH-1:0]      req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_wdata,
    output logic                  req1_gnt,
    output logic                  req1_done,
    output logic                  req1_err,
    output logic [WIDTH-1:0]      req1_rdata,
    output logic                  m_valid,
    output logic                  m_wr_rd,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic [WIDTH-1:0]      m_rdata,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic          owner;     // requester that owns the command in flight
    logic          last;      // requester served last; 1 after reset so req0 is favoured
    logic [CW-1:0] wd_cnt;    // WAIT cycles that ended without m_ready
    logic          pick1;     // requester 1 wins if the accept happens now

    // With both pending, the one that was not served last wins.
    always_comb begin
        pick1 = req1_valid;
        if (req0_valid && req1_valid) begin
            pick1 = ~last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            wd_cnt     <= '0;
            req0_gnt   <= 1'b0;
            req0_done  <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= '0;
            req1_gnt   <= 1'b0;
            req1_done  <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= '0;
            m_valid    <= 1'b0;
            m_wr_rd    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            busy       <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            req0_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_done <= 1'b0;
            req1_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        owner    <= pick1;
                        m_valid  <= 1'b1;
                        m_wr_rd  <= pick1 ? req1_wr    : req0_wr;
                        m_addr   <= pick1 ? req1_addr  : req0_addr;
                        m_wdata  <= pick1 ? req1_wdata : req0_wdata;
                        req0_gnt <= ~pick1;
                        req1_gnt <= pick1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    m_valid  <= 1'b0;
                    req0_gnt <= 1'b0;
                    req1_gnt <= 1'b0;
                    wd_cnt   <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (m_ready) begin
                        if (owner) begin
                            req1_done <= 1'b1;
                            if (!m_wr_rd) req1_rdata <= m_rdata;
                        end else begin
                            req0_done <= 1'b1;
                            if (!m_wr_rd) req0_rdata <= m_rdata;
                        end
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        // This silent cycle is the TIMEOUT-th one: abort.
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_err  <= 1'b1;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= 1'b1;
                        end
                        last  <= owner;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: a behavioural single-port memory with an
// optional stall, plus a transaction-level reference model. The model keeps
// the memory contents, the read data each requester should hold and the last
// requester served.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_wr, req0_gnt, req0_done, req0_err;
    logic [4:0] req0_addr;
    logic [7:0] req0_wdata, req0_rdata;
    logic       req1_valid, req1_wr, req1_gnt, req1_done, req1_err;
    logic [4:0] req1_addr;
    logic [7:0] req1_wdata, req1_rdata;
    logic       m_valid, m_wr_rd, m_ready, busy;
    logic [4:0] m_addr;
    logic [7:0] m_wdata, m_rdata;

    mem_port_arbiter #(.WIDTH(8), .DEPTH(32), .ADDR_WIDTH(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_gnt(req0_gnt), .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_gnt(req1_gnt), .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
        .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural memory ----------------
    logic       preload;
    logic       stall;
    logic [7:0] mem [32];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 31) ? 8'h3C : 8'h00;
            m_ready <= 1'b0;
            m_rdata <= 8'h00;
        end else if (m_valid && !stall) begin
            m_ready <= 1'b1;
            if (m_wr_rd) mem[m_addr] <= m_wdata;
            else         m_rdata     <= mem[m_addr];
        end else begin
            m_ready <= 1'b0;
        end
    end

    // ---------------- reference model / scoreboard state ----------------
    logic       c_valid [2];
    logic       c_wr    [2];
    logic [4:0] c_addr  [2];
    logic [7:0] c_data  [2];
    logic [7:0] exp_rd  [2];
    logic [7:0] mem_ref [32];
    int         last_ref;
    int         done_cyc;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply();
        req0_valid = c_valid[0]; req0_wr = c_wr[0]; req0_addr = c_addr[0]; req0_wdata = c_data[0];
        req1_valid = c_valid[1]; req1_wr = c_wr[1]; req1_addr = c_addr[1]; req1_wdata = c_data[1];
    endtask

    task automatic set_cmd(input int r, input logic wr, input logic [4:0] a, input logic [7:0] d);
        c_valid[r] = 1'b1; c_wr[r] = wr; c_addr[r] = a; c_data[r] = d;
        apply();
    endtask

    task automatic drop(input int r);
        c_valid[r] = 1'b0;
        apply();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt0"},  32'(req0_gnt),   32'd0);
        check({tag, "_done0"}, 32'(req0_done),  32'd0);
        check({tag, "_err0"},  32'(req0_err),   32'd0);
        check({tag, "_rd0"},   32'(req0_rdata), 32'd0);
        check({tag, "_gnt1"},  32'(req1_gnt),   32'd0);
        check({tag, "_done1"}, 32'(req1_done),  32'd0);
        check({tag, "_err1"},  32'(req1_err),   32'd0);
        check({tag, "_rd1"},   32'(req1_rdata), 32'd0);
        check({tag, "_mval"},  32'(m_valid),    32'd0);
        check({tag, "_mwr"},   32'(m_wr_rd),    32'd0);
        check({tag, "_maddr"}, 32'(m_addr),     32'd0);
        check({tag, "_mwd"},   32'(m_wdata),    32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            c_valid[r] = 1'b0;
            exp_rd[r]  = 8'h00;
        end
        last_ref = 1;
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
    endtask

    // Serve one command end to end. The winner is predicted from the pending
    // set and the last requester served. Every cycle from grant to completion
    // is checked against the model.
    task automatic serve(input logic stl, output int w);
        int   waited;
        int   gc;
        logic twr;
        logic [4:0] ta;
        logic [7:0] td;
        w = (c_valid[0] && c_valid[1]) ? (1 - last_ref) : (c_valid[1] ? 1 : 0);
        stall = stl;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(req0_gnt || req1_gnt) && waited < 16);
        if (!(req0_gnt || req1_gnt)) begin
            check("gnt_seen", 32'd0, 32'd1);
            stall = 1'b0;
            return;
        end
        gc = cyc;
        twr = c_wr[w]; ta = c_addr[w]; td = c_data[w];
        check("gnt0",   32'(req0_gnt), 32'(w == 0));
        check("gnt1",   32'(req1_gnt), 32'(w == 1));
        check("mvalid", 32'(m_valid),  32'd1);
        check("mwr",    32'(m_wr_rd),  32'(twr));
        check("maddr",  32'(m_addr),   32'(ta));
        if (twr) check("mwdata", 32'(m_wdata), 32'(td));
        check("busy_g", 32'(busy), 32'd1);
        check("done_g", 32'({req0_done, req1_done}), 32'd0);
        drop(w);

        @(negedge clk);
        check("gnt_off", 32'({req0_gnt, req1_gnt}), 32'd0);
        check("mv_off",  32'(m_valid), 32'd1 - 32'd1);
        check("busy_i",  32'(busy), 32'd1);

        if (stl) begin
            repeat (TIMEOUT - 1) begin
                @(negedge clk);
                check("done_wait", 32'({req0_done, req1_done}), 32'd0);
                check("busy_w",    32'(busy), 32'd1);
            end
        end

        @(negedge clk);
        check("done_w",  32'(w ? req1_done : req0_done), 32'd1);
        check("done_o",  32'(w ? req0_done : req1_done), 32'd0);
        check("err_w",   32'(w ? req1_err : req0_err), 32'(stl));
        check("err_o",   32'(w ? req0_err : req1_err), 32'd0);
        check("busy_d",  32'(busy), 32'd0);
        check("latency", 32'(cyc - gc), stl ? 32'(TIMEOUT + 1) : 32'd2);
        if (!stl) begin
            if (twr) mem_ref[ta] = td;
            else     exp_rd[w]   = mem_ref[ta];
        end
        check("rdata0", 32'(req0_rdata), 32'(exp_rd[0]));
        check("rdata1", 32'(req1_rdata), 32'(exp_rd[1]));
        last_ref = w;
        done_cyc = cyc;
        stall = 1'b0;
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "time limit");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int w;
        int prev;
        int waited;
        preload = 1'b1;
        stall   = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 32; i++) mem_ref[i] = 8'h00;
        mem_ref[31] = 8'h3C;
        for (int r = 0; r < 2; r++) begin
            c_wr[r] = 1'b0; c_addr[r] = 5'd0; c_data[r] = 8'd0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        preload = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Write then read back on requester 0.
        set_cmd(0, 1'b1, 5'd5, 8'hA5); serve(1'b0, w);
        set_cmd(0, 1'b0, 5'd5, 8'h00); serve(1'b0, w);
        check("rd_a5", 32'(req0_rdata), 32'hA5);

        // Both held continuously: alternating grants, completions 3 cycles apart.
        do_reset();
        set_cmd(0, 1'b1, 5'd1, 8'h11);
        set_cmd(1, 1'b1, 5'd2, 8'h22);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            serve(1'b0, w);
            if (i > 0) check("done_spacing", 32'(done_cyc - prev), 32'd3);
            prev = done_cyc;
            if (w == 0) set_cmd(0, 1'b1, 5'd1, 8'h11);
            else        set_cmd(1, 1'b1, 5'd2, 8'h22);
        end
        drop(0); drop(1);

        // Requester 1 alone, back-to-back reads of the top address.
        for (int i = 0; i < 4; i++) begin
            set_cmd(1, 1'b0, 5'd31, 8'h00);
            serve(1'b0, w);
            check("rd31_r1", 32'(req1_rdata), 32'h3C);
            check("rd31_r0", 32'(req0_rdata), 32'h00);
        end

        // Silent memory: watchdog abort keeps prior read data.
        set_cmd(1, 1'b0, 5'd7, 8'h00);
        serve(1'b1, w);
        check("to_keep", 32'(req1_rdata), 32'h3C);
        @(negedge clk);
        check("to_busy", 32'(busy), 32'd0);

        // Reset while a requester-1 write waits for its response.
        set_cmd(1, 1'b1, 5'd9, 8'h99);
        stall = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req1_gnt && waited < 16);
        check("rst_gnt1", 32'(req1_gnt), 32'd1);
        drop(1);
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_zero("rst_after");
        set_cmd(0, 1'b1, 5'd3, 8'h33);
        set_cmd(1, 1'b1, 5'd4, 8'h44);
        serve(1'b0, w);
        serve(1'b0, w);

        // Read/write mix on requester 0.
        set_cmd(0, 1'b1, 5'd0, 8'hFF); serve(1'b0, w);
        set_cmd(0, 1'b0, 5'd0, 8'h00); serve(1'b0, w);
        check("mix_rd", 32'(req0_rdata), 32'hFF);
        set_cmd(0, 1'b1, 5'd0, 8'h12); serve(1'b0, w);
        check("mix_keep", 32'(req0_rdata), 32'hFF);

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (!c_valid[0] && !c_valid[1]) repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!c_valid[r] && $urandom_range(0, 2) != 0)
                    set_cmd(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                            8'($urandom_range(0, 255)));
            end
            if (!c_valid[0] && !c_valid[1])
                set_cmd(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            serve(1'($urandom_range(0, 5) == 0), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
